// File: rtl/oppm_frame_tx.sv
// oppm_frame_tx: FIFO-fed OPPM framer; each frame is preamble, data symbols, optional parity, optional gap.
module oppm_frame_tx #(
  parameter int PULSE_CT  = 1,
  parameter int N_MOD     = 2,
  parameter int L         = 4,
  parameter int N_PKT     = 8,
  parameter int PRE_CT    = 3,
  parameter int PARITY_EN = 1,
  parameter int GAP_SYM   = 0,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_PKT-1:0]         data_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     pulse,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     frame_done
);
  localparam int P    = L * (2 ** N_MOD);
  localparam int NSYM = N_PKT / N_MOD;
  localparam int CW   = $clog2(P);
  localparam int SW   = $clog2(PRE_CT + NSYM + GAP_SYM + 1);
  localparam int AW   = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, GAP} state_t;
  state_t           r_state, w_nstate;
  logic [N_PKT-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_count;
  logic             r_rdy_en, r_pulse;
  logic [N_PKT-1:0] r_pkt, w_shift;
  logic [CW-1:0]    r_cyc, w_ncyc;
  logic [SW-1:0]    r_sym, w_nsym;
  logic             w_push, w_pop, w_last, w_end, w_pulse;
  logic [N_MOD-1:0] w_par, w_val;
  assign in_ready   = r_rdy_en && (r_count < (AW+1)'(DEPTH));
  assign w_push     = in_valid && in_ready;
  assign fifo_count = r_count;
  assign busy       = r_state != IDLE;
  assign pulse      = r_pulse;
  assign frame_done = w_end;
  assign w_last     = r_cyc == CW'(P - 1);
  // Last cycle of the frame: end of gap, or end of the final transmitted symbol when there is no gap.
  assign w_end = w_last && ((r_state == GAP && r_sym == SW'(GAP_SYM - 1)) ||
                 (GAP_SYM == 0 && (PARITY_EN != 0 ? r_state == PAR :
                                   (r_state == DATA && r_sym == SW'(NSYM - 1)))));
  always_comb begin
    w_par = '0;
    for (int i = 0; i < NSYM; i++) w_par = w_par ^ r_pkt[i*N_MOD +: N_MOD];
  end
  always_comb begin
    w_nstate = r_state;
    w_ncyc   = (r_state == IDLE || w_last) ? '0 : r_cyc + 1'b1;
    w_nsym   = r_sym;
    w_pop    = 1'b0;
    if (r_state == IDLE || w_end) begin
      w_pop    = r_count != '0;
      w_nstate = w_pop ? PRE : IDLE;
      w_nsym   = '0;
    end else if (w_last) begin
      w_nsym = r_sym + 1'b1;
      case (r_state)
        PRE: if (r_sym == SW'(PRE_CT - 1)) begin
          w_nstate = DATA;
          w_nsym   = '0;
        end
        DATA: if (r_sym == SW'(NSYM - 1)) begin
          w_nstate = PARITY_EN != 0 ? PAR : GAP;
          w_nsym   = '0;
        end
        PAR: begin
          w_nstate = GAP;
          w_nsym   = '0;
        end
        default: ;
      endcase
    end
  end
  // Pulse is registered, so it is decoded from the state/counters of the coming cycle.
  assign w_shift = r_pkt << (int'(w_nsym) * N_MOD);
  assign w_val   = w_nstate == PRE ? '1 : w_nstate == PAR ? w_par : w_shift[N_PKT-1 -: N_MOD];
  assign w_pulse = (w_nstate == PRE || w_nstate == DATA || w_nstate == PAR) &&
                   int'(w_ncyc) >= int'(w_val) * L && int'(w_ncyc) < int'(w_val) * L + PULSE_CT;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cyc    <= '0;
      r_sym    <= '0;
      r_pulse  <= 1'b0;
      r_pkt    <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_count  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_cyc    <= w_ncyc;
      r_sym    <= w_nsym;
      r_pulse  <= w_pulse;
      r_rdy_en <= 1'b1;
      r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) begin
        r_pkt <= r_mem[r_rp];
        r_rp  <= r_rp + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= data_in;
  end
endmodule

// File: tb/tb_oppm_frame_tx.sv
// tb_oppm_frame_tx: scoreboard bench; u0 uses defaults, u1 has parity off, 2 gap symbols, 3-clock pulses.
module tb_oppm_frame_tx;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] d0 = '0, d1 = '0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic       rdy0, rdy1, p0, p1, b0, b1, fd0, fd1;
  logic [2:0] c0, c1;
  oppm_frame_tx u0 (
    .clk(clk), .rst_n(rst_n), .data_in(d0), .in_valid(v0), .in_ready(rdy0),
    .pulse(p0), .busy(b0), .fifo_count(c0), .frame_done(fd0));
  oppm_frame_tx #(.PULSE_CT(3), .PARITY_EN(0), .GAP_SYM(2)) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(d1), .in_valid(v1), .in_ready(rdy1),
    .pulse(p1), .busy(b1), .fifo_count(c1), .frame_done(fd1));
  typedef struct packed {
    logic [15:0] syms;
    logic        contig;
  } exp_t;
  exp_t q0[$], q1[$];
  int checks = 0, errors = 0, stray = 0;
  task automatic check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask
  // Monitor: decode each frame's pulse positions into 2-bit symbols (MSB-first word) and score it.
  int          t[2], np[2], werr[2], w[2];
  logic [15:0] got[2];
  logic        inf[2], pp[2], pd[2], ct[2];
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic pu, bu, dn;
      int   qs;
      exp_t e;
      pu = k != 0 ? p1 : p0;
      bu = k != 0 ? b1 : b0;
      dn = k != 0 ? fd1 : fd0;
      if (!rst_n) begin
        inf[k] = 1'b0;
        pp[k]  = 1'b0;
        pd[k]  = 1'b0;
        w[k]   = 0;
      end else begin
        if (bu && !inf[k]) begin
          inf[k]  = 1'b1;
          t[k]    = 0;
          got[k]  = '0;
          np[k]   = 0;
          werr[k] = 0;
          ct[k]   = pd[k];
        end else if (bu) t[k]++;
        if (pu && !bu) stray++;
        if (pu && !pp[k] && bu) begin
          if (t[k] % 4 != 0 || t[k] >= 128) werr[k]++;
          else got[k] |= 16'((t[k] % 16) / 4) << (14 - 2 * (t[k] / 16));
          np[k]++;
        end
        if (pu) w[k]++;
        else begin
          if (pp[k] && w[k] != (k != 0 ? 3 : 1)) werr[k]++;
          w[k] = 0;
        end
        if (dn) begin
          qs = k != 0 ? q1.size() : q0.size();
          check($sformatf("u%0d frame expected", k), int'(qs != 0), 1);
          if (qs != 0) begin
            if (k != 0) e = q1.pop_front();
            else e = q0.pop_front();
            check($sformatf("u%0d symbols", k), got[k], e.syms);
            check($sformatf("u%0d pulse count", k), np[k], k != 0 ? 7 : 8);
            check($sformatf("u%0d frame length", k), t[k] + 1, k != 0 ? 144 : 128);
            check($sformatf("u%0d pulse shape errors", k), werr[k], 0);
            check($sformatf("u%0d contiguous start", k), ct[k], e.contig);
          end
          inf[k] = 1'b0;
        end
        pp[k] = pu;
        pd[k] = dn;
      end
    end
  end
  task automatic put0(input logic [7:0] d);
    d0 = d;
    v0 = 1'b1;
    @(negedge clk);
  endtask
  task automatic exp0(input logic [15:0] s, input logic c);
    q0.push_back('{syms: s, contig: c});
  endtask
  task automatic wait_fd0(input int max);
    int n = 0;
    while (!fd0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("u0 frame_done seen", fd0, 1);
  endtask
  task automatic settle(input int k, input int max);
    int n = 0;
    while (n < max && ((k != 0 ? q1.size() : q0.size()) != 0 || (k != 0 ? b1 : b0))) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("u%0d drained in time", k), int'(n < max), 1);
  endtask
  initial begin
    int quiet;
    #1;
    check("reset pulse", p0, 0);
    check("reset busy", b0, 0);
    check("reset in_ready", rdy0, 0);
    check("reset fifo_count", c0, 0);
    check("reset frame_done", fd0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("in_ready before first edge", rdy0, 0);
    @(negedge clk);
    check("u0 in_ready after first edge", rdy0, 1);
    check("u1 in_ready after first edge", rdy1, 1);
    exp0(16'hFED0, 1'b0);
    put0(8'hB4);
    v0 = 1'b0;
    check("busy before pop", b0, 0);
    @(negedge clk);
    check("busy at S", b0, 1);
    wait_fd0(200);
    @(negedge clk);
    check("busy after frame", b0, 0);
    exp0(16'hFC05, 1'b0);
    exp0(16'hFE02, 1'b1);
    exp0(16'hFCDD, 1'b1);
    exp0(16'hFD68, 1'b1);
    exp0(16'hFFFC, 1'b1);
    put0(8'h01);
    put0(8'h80);
    put0(8'h37);
    put0(8'h5A);
    put0(8'hFF);
    check("count after 5 pushes", c0, 4);
    check("in_ready when full", rdy0, 0);
    d0 = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      check("count stays full", c0, 4);
    end
    v0 = 1'b0;
    settle(0, 800);
    exp0(16'hFC00, 1'b0);
    exp0(16'hFED0, 1'b1);
    exp0(16'hFC6C, 1'b1);
    exp0(16'hFE02, 1'b1);
    put0(8'h00);
    put0(8'hB4);
    put0(8'h1B);
    v0 = 1'b0;
    check("count before overlap", c0, 2);
    wait_fd0(200);
    put0(8'h80);
    v0 = 1'b0;
    check("count after push+pop", c0, 2);
    settle(0, 700);
    q1.push_back('{syms: 16'hFC6C, contig: 1'b0});
    d1 = 8'h1B;
    v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    settle(1, 300);
    put0(8'hB4);
    put0(8'hFF);
    put0(8'h80);
    v0 = 1'b0;
    check("queued before reset", c0, 2);
    repeat (49) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid-frame reset pulse", p0, 0);
    check("mid-frame reset busy", b0, 0);
    check("mid-frame reset fifo_count", c0, 0);
    check("mid-frame reset in_ready", rdy0, 0);
    check("mid-frame reset frame_done", fd0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("in_ready just after release", rdy0, 0);
    @(negedge clk);
    check("in_ready after release edge", rdy0, 1);
    check("fifo_count after release", c0, 0);
    quiet = 0;
    repeat (300) begin
      @(negedge clk);
      if (p0 || b0) quiet++;
    end
    check("quiet after reset", quiet, 0);
    exp0(16'hFED0, 1'b0);
    put0(8'hB4);
    v0 = 1'b0;
    settle(0, 300);
    check("stray pulses", stray, 0);
    check("u0 queue empty", q0.size(), 0);
    check("u1 queue empty", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
